// File: rtl/sprite_shape_writer.sv
// Write side of the shared sprite shape RAM: one shape id, then LINES words.
// Define SHAPE_WRITE_VERIFY_EN to read back each line and flag mismatches.
module sprite_shape_writer #(
  parameter int ID_W   = 6,
  parameter int LINES  = 16,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ID_W-1:0]   cmd_id,
  input  logic              line_valid,
  output logic              line_ready,
  input  logic [DATA_W-1:0] line_data,
  input  logic              abort,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic [ADDR_W-1:0] addr_out,
  output logic [DATA_W-1:0] data_out,
  output logic              wren_out,
  input  logic [DATA_W-1:0] data_in,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int LW = $clog2(LINES);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_LOAD  = 3'd2,
    S_WRITE = 3'd3,
`ifdef SHAPE_WRITE_VERIFY_EN
    S_RD    = 3'd5,
    S_CMP   = 3'd6,
`endif
    S_DONE  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [LW-1:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              wren_q, wren_d;
  logic              done_q, done_d;
  logic              req_q, req_d;
  logic              busy_q, busy_d;
  logic [ADDR_W-1:0] base;
  logic              last;

  assign base = ADDR_W'(id_q) << LW;
  assign last = (cnt_q == LW'(LINES - 1));

`ifdef SHAPE_WRITE_VERIFY_EN
  logic err_q, err_d;
`else
  logic unused_data_in;
  assign unused_data_in = ^data_in;
`endif

  always_comb begin
    state_d    = state_q;
    id_d       = id_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    data_d     = data_q;
`ifdef SHAPE_WRITE_VERIFY_EN
    err_d      = err_q;
`endif
    cmd_ready  = (state_q == S_IDLE);
    line_ready = (state_q == S_LOAD) && mem_gnt;

    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (cmd_valid && !abort) begin
            id_d    = cmd_id;
            cnt_d   = '0;
`ifdef SHAPE_WRITE_VERIFY_EN
            err_d   = 1'b0;
`endif
            state_d = S_REQ;
          end
        end
        S_REQ: begin
          if (mem_gnt) state_d = S_LOAD;
        end
        S_LOAD: begin
          if (!mem_gnt) begin
            state_d = S_REQ;
          end else if (line_valid) begin
            addr_d  = base + ADDR_W'(cnt_q);
            data_d  = line_data;
            state_d = S_WRITE;
          end
        end
`ifdef SHAPE_WRITE_VERIFY_EN
        S_WRITE: state_d = S_RD;
        S_RD:    state_d = S_CMP;
        S_CMP: begin
          // read data lands one cycle after the address was held in RD
          if (data_in != data_q) err_d = 1'b1;
          if (last) begin
            state_d = S_DONE;
          end else begin
            cnt_d   = cnt_q + LW'(1);
            state_d = S_LOAD;
          end
        end
`else
        S_WRITE: begin
          if (last) begin
            state_d = S_DONE;
          end else begin
            cnt_d   = cnt_q + LW'(1);
            state_d = S_LOAD;
          end
        end
`endif
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end

    wren_d = (state_d == S_WRITE);
    done_d = (state_d == S_DONE);
    req_d  = (state_d != S_IDLE);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      id_q    <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      wren_q  <= 1'b0;
      done_q  <= 1'b0;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
`ifdef SHAPE_WRITE_VERIFY_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wren_q  <= wren_d;
      done_q  <= done_d;
      req_q   <= req_d;
      busy_q  <= busy_d;
`ifdef SHAPE_WRITE_VERIFY_EN
      err_q   <= err_d;
`endif
    end
  end

  assign mem_req  = req_q;
  assign addr_out = addr_q;
  assign data_out = data_q;
  assign wren_out = wren_q;
  assign busy     = busy_q;
  assign done     = done_q;
`ifdef SHAPE_WRITE_VERIFY_EN
  assign error    = err_q;
`else
  assign error    = 1'b0;
`endif

endmodule

// File: tb/tb_sprite_shape_writer.sv
// Randomised bench for sprite_shape_writer against a line-level model.
// Honours SHAPE_WRITE_VERIFY_EN for read-back timing and error checks.
module tb_sprite_shape_writer;

  localparam int BUDGET = 2000;
`ifdef SHAPE_WRITE_VERIFY_EN
  localparam bit VER    = 1'b1;
  localparam int HOLD   = 3;
  localparam int DONE_E = 65;
`else
  localparam bit VER    = 1'b0;
  localparam int HOLD   = 1;
  localparam int DONE_E = 33;
`endif

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [5:0]  cmd_id;
  logic        line_valid;
  logic        line_ready;
  logic [15:0] line_data;
  logic        abort;
  logic        mem_req;
  logic        mem_gnt;
  logic [15:0] addr_out;
  logic [15:0] data_out;
  logic        wren_out;
  logic [15:0] data_in;
  logic        busy;
  logic        done;
  logic        error;

  sprite_shape_writer dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_id     (cmd_id),
    .line_valid (line_valid),
    .line_ready (line_ready),
    .line_data  (line_data),
    .abort      (abort),
    .mem_req    (mem_req),
    .mem_gnt    (mem_gnt),
    .addr_out   (addr_out),
    .data_out   (data_out),
    .wren_out   (wren_out),
    .data_in    (data_in),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    else
      n_pass++;
  endtask

  // RAM attached to the write port; one address may be made to corrupt
  logic [15:0] ram     [0:65535];
  logic [15:0] exp_ram [0:65535];
  int          corrupt_addr = -1;

  always @(posedge clk) begin
    if (wren_out === 1'b1)
      ram[addr_out] = (int'(addr_out) == corrupt_addr) ?
                      (data_out ^ 16'h0001) : data_out;
    data_in <= ram[addr_out];
  end

  // Line-level model: an upload is a sequence of waits for the port,
  // line acceptances, and a fixed post-write hold of HOLD cycles.
  bit          started = 0;
  bit          m_act, m_load, m_fin;
  int          m_hold, m_idx;
  logic [15:0] m_base;
  logic [15:0] e_addr, e_data;
  bit          e_wren, e_done, e_err;

  always @(posedge clk) begin
    started = 1;
    e_wren  = 0;
    e_done  = 0;
    if (rst) begin
      m_act = 0; m_load = 0; m_fin = 0; m_hold = 0; m_idx = 0;
      e_addr = 0; e_data = 0; e_err = 0;
    end else if (!m_act) begin
      if (cmd_valid && !abort) begin
        m_act  = 1;
        m_base = 16'(cmd_id) * 16'd16;
        m_idx  = 0; m_load = 0; m_hold = 0; m_fin = 0;
        e_err  = 0;
      end
    end else if (abort) begin
      m_act = 0;
    end else if (m_fin) begin
      m_act = 0;
    end else if (m_hold > 0) begin
      if (VER && m_hold == 1 && data_in !== e_data) e_err = 1;
      m_hold--;
      if (m_hold == 0) begin
        if (m_idx == 15) begin
          m_fin  = 1;
          e_done = 1;
        end else begin
          m_idx++;
          m_load = 1;
        end
      end
    end else if (!m_load) begin
      m_load = mem_gnt;
    end else if (!mem_gnt) begin
      m_load = 0;
    end else if (line_valid) begin
      e_wren = 1;
      e_addr = m_base + 16'(m_idx);
      e_data = line_data;
      exp_ram[e_addr] = e_data;
      m_hold = HOLD;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("cmd_ready", 32'(cmd_ready), 32'(!m_act));
      chk("line_ready", 32'(line_ready),
          32'(m_act && !m_fin && m_hold == 0 && m_load && mem_gnt));
      chk("busy", 32'(busy), 32'(m_act));
      chk("mem_req", 32'(mem_req), 32'(m_act));
      chk("wren", 32'(wren_out), 32'(e_wren));
      chk("done", 32'(done), 32'(e_done));
      chk("addr", 32'(addr_out), 32'(e_addr));
      chk("data", 32'(data_out), 32'(e_data));
      chk("error", 32'(error), 32'(e_err));
    end
  end

  logic err_at_accept;

  task automatic upload(input int id, input int gm, input int dm,
                        input int ab_after, input bit rab,
                        output int nw, output int nd,
                        output int first_e, output int done_e);
    int e, stall, drop;
    nw = 0; nd = 0; first_e = -1; done_e = -1;
    e = 0; stall = 0; drop = 0;
    cmd_id     = 6'(id);
    cmd_valid  = 1'b1;
    abort      = 1'b0;
    mem_gnt    = (gm == 1) ? 1'b0 : 1'b1;
    line_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid     = 1'b0;
    err_at_accept = error;
    while (m_act && e < BUDGET) begin
      mem_gnt    = 1'b1;
      line_valid = 1'b1;
      abort      = 1'b0;
      if (gm == 1) begin
        if (e < 5) begin
          mem_gnt = 1'b0;
        end else if (m_hold == 0 && !m_fin) begin
          if (m_idx == 7 && m_load && stall < 3) begin
            line_valid = 1'b0;
            stall++;
          end
          if (m_idx == 9 && drop < 2 && (drop > 0 || m_load)) begin
            mem_gnt = 1'b0;
            drop++;
          end
        end
      end else if (gm == 2) begin
        if (m_hold == 0 && !m_fin)
          mem_gnt = ($urandom_range(0, 3) != 0);
        line_valid = ($urandom_range(0, 2) != 0);
        if (rab && $urandom_range(0, 59) == 0) abort = 1'b1;
      end
      if (ab_after >= 0 && nw == ab_after) abort = 1'b1;
      case (dm)
        0:       line_data = 16'hFFFF;
        1:       line_data = 16'(m_idx);
        default: line_data = 16'($urandom);
      endcase
      @(posedge clk); #1;
      e++;
      if (wren_out === 1'b1) begin
        nw++;
        if (first_e < 0) first_e = e;
      end
      if (done === 1'b1) begin
        nd++;
        done_e = e;
      end
    end
    abort   = 1'b0;
    mem_gnt = 1'b1;
    chk("timeout", 32'(e < BUDGET), 32'd1);
  endtask

  initial begin
    int nw, nd, fe, de, bad;
    rst = 1'b1; cmd_valid = 1'b0; cmd_id = '0; line_valid = 1'b0;
    line_data = '0; abort = 1'b0; mem_gnt = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_addr", 32'(addr_out), 32'd0);
    chk("rst_error", 32'(error), 32'd0);

    upload(1, 0, 0, -1, 0, nw, nd, fe, de);
    chk("full_writes", 32'(nw), 32'd16);
    chk("full_done", 32'(nd), 32'd1);
    chk("full_first_wren_edge", 32'(fe), 32'd2);
    chk("full_done_edge", 32'(de), 32'(DONE_E));
    chk("full_ram16", 32'(ram[16]), 32'h0000FFFF);
    chk("full_ram31", 32'(ram[31]), 32'h0000FFFF);

    upload(63, 0, 1, -1, 0, nw, nd, fe, de);
    chk("id63_writes", 32'(nw), 32'd16);
    chk("id63_ram1008", 32'(ram[1008]), 32'd0);
    chk("id63_ram1015", 32'(ram[1015]), 32'd7);
    chk("id63_ram1023", 32'(ram[1023]), 32'd15);

    upload(5, 1, 2, -1, 0, nw, nd, fe, de);
    chk("stall_writes", 32'(nw), 32'd16);
    chk("stall_done", 32'(nd), 32'd1);

    upload(2, 0, 2, 5, 0, nw, nd, fe, de);
    chk("abort_writes", 32'(nw), 32'd5);
    chk("abort_no_done", 32'(nd), 32'd0);
    chk("abort_mem_req", 32'(mem_req), 32'd0);
    chk("abort_cmd_ready", 32'(cmd_ready), 32'd1);

    cmd_valid = 1'b1; abort = 1'b1; cmd_id = 6'd9;
    @(posedge clk); #1;
    cmd_valid = 1'b0; abort = 1'b0;
    chk("abort_vs_cmd_busy", 32'(busy), 32'd0);

    if (VER) begin
      corrupt_addr = 20;
      upload(1, 0, 0, -1, 0, nw, nd, fe, de);
      chk("verify_error_set", 32'(error), 32'd1);
      corrupt_addr = -1;
      upload(3, 0, 2, -1, 0, nw, nd, fe, de);
      chk("verify_error_cleared", 32'(err_at_accept), 32'd0);
    end else begin
      chk("no_verify_error", 32'(error), 32'd0);
    end

    for (int i = 0; i < 12; i++)
      upload(int'($urandom_range(0, 63)), 2, 2, -1, 1, nw, nd, fe, de);

    cmd_valid = 1'b1; cmd_id = 6'd10; mem_gnt = 1'b1; line_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_wren", 32'(wren_out), 32'd0);
    chk("midrst_addr", 32'(addr_out), 32'd0);

    bad = 0;
    for (int a = 0; a < 1024; a++) begin
      if (!(VER && a == 20) && ram[a] !== exp_ram[a]) bad++;
    end
    chk("ram_scoreboard", 32'(bad), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
